posicionador_embarcacao: RTL and testbench
==========================================

// Module: posicionador_embarcacao
// PURPOSE
//  Writer side of the ship-position bus consumed by the VGA ship renderers.
//  Moves a placement cursor on the 8x8 map from player button presses and
//  builds the packed posicoesEmbarcacao vector for a ship of 1..4 cells.
//  Publishes the vector with a one-cycle readEnabled strobe on confirm.
//  One instance per ship; sits between the input debouncers and the VGA layer.
// PARAMETERS
//  GRID       8   map side in cells; coordinates run 1..GRID
//  MAX_CELLS  4   max ship length; posicoesEmbarcacao holds MAX_CELLS slots
//  CELL_W     16  bits per cell slot; bus width = MAX_CELLS*CELL_W = 64
// PORTS
//  clk                 in   1   system clock (VGA pixel clock domain)
//  rst_n               in   1   asynchronous active-low reset
//  start               in   1   level; rising edge begins a new placement
//  tamanho             in   3   ship length, sampled on start edge
//  btn_cima/btn_baixo  in   1   debounced levels; Y+1 / Y-1
//  btn_esq/btn_dir     in   1   debounced levels; X-1 / X+1
//  btn_girar           in   1   debounced level; toggle orientation
//  btn_confirma        in   1   debounced level; commit placement
//  posicoesEmbarcacao  out  64  packed cell coordinates (format below)
//  readEnabled         out  1   one-cycle strobe: new vector valid
//  cursorX, cursorY    out  4   current anchor cell, 1..8
//  horizontal          out  1   1 = cells grow +X, 0 = cells grow +Y
//  busy                out  1   high in MOVE/WRITE/PUBLISH
//  done                out  1   high in DONE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; cursorX=cursorY=1; horizontal=1;
//   posicoesEmbarcacao=0; readEnabled=0; busy=0; done=0; edge regs=0.
//   Reset mid-operation aborts and clears everything; no partial publish.
//  Edge detect: every button and start registered each cycle;
//   edge = in & ~in_q. Only edges act; held buttons do nothing further.
//  Length L = tamanho, with 0 -> 1 and >4 -> 4; latched on start edge.
//  Slot k (k=0..L-1) bits [16k+15:16k]: bit0 = valid, [6:3] = X,
//   [10:7] = Y, all other bits 0. Unused slots are all-zero.
//  Cell k: horizontal ? (cursorX+k, cursorY) : (cursorX, cursorY+k).
//  FSM:
//   IDLE    : start edge -> MOVE; cursor=(1,1), horizontal=1.
//   MOVE    : at most one action per cycle, priority
//             confirma > girar > cima > baixo > esq > dir.
//             Moves saturate: anchor stays in 1..8 and the whole ship
//             stays on-map (horizontal: X <= 9-L; vertical: Y <= 9-L).
//             Out-of-range moves are ignored (no wrap-around).
//             girar toggles only if the rotated ship fits, else ignored.
//             confirma -> WRITE, cell counter=0, shadow vector cleared.
//   WRITE   : one slot per cycle into shadow; after slot L-1 -> PUBLISH.
//             Inputs ignored. Duration exactly L cycles.
//   PUBLISH : posicoesEmbarcacao <= shadow, readEnabled <= 1 -> DONE.
//   DONE    : readEnabled back to 0 next cycle; outputs hold the vector.
//             start edge -> MOVE (new placement; old vector held until
//             the next PUBLISH overwrites it).
//  Latency: confirm edge in cycle N -> readEnabled high in cycle N+L+2,
//   high for exactly one cycle.
//  start edge in MOVE/WRITE/PUBLISH is ignored.
//  Vector changes only on the PUBLISH edge; never glitches otherwise.
// TESTING
//  T1 reset: assert rst_n=0 mid-WRITE -> all outputs 0, cursor (1,1), IDLE.
//  T2 L=1, start, dir x3, cima x2, confirma -> slot0 X=4,Y=3,valid;
//     vector = 64'h0000_0000_0000_01A1; readEnabled one cycle at N+3.
//  T3 L=4 horizontal, dir x10 -> cursorX saturates at 5; confirma ->
//     slots X=5,6,7,8, Y=1; readEnabled at N+6.
//  T4 L=3, cursorX=7 vertical, girar -> ignored (7+2>8), horizontal stays 0.
//  T5 cima and dir and girar asserted same cycle -> only girar acts;
//     holding dir 20 cycles -> cursor moves exactly one cell.
//  T6 tamanho=0 -> one slot; tamanho=7 -> four slots; second start from
//     DONE keeps old vector until the new PUBLISH.

Source files
------------

// File: rtl/posicionador_embarcacao_if.sv
// Ship-position bus between one placement writer and the VGA ship renderers.
//
// Signals:
//   posicoesEmbarcacao  W bits  packed cell slots (16 bits per slot)
//   readEnabled         1 bit   one-cycle strobe: vector just became valid
//
// Handshake: strobe-only, no back-pressure. readEnabled is a valid pulse that
// lasts exactly one clock; the vector is stable from that cycle until the
// next pulse, so a reader may sample it on the strobe or at any later time.
//
// Modports: master = writer (posicionador_embarcacao), slave = renderers.
interface posicionador_embarcacao_if #(
  parameter int W = 64
);
  logic [W-1:0] posicoesEmbarcacao;
  logic         readEnabled;

  modport master (output posicoesEmbarcacao, output readEnabled);
  modport slave  (input  posicoesEmbarcacao, input  readEnabled);
endinterface

// File: rtl/posicionador_embarcacao.sv
// Placement cursor for one ship on the 8x8 map. Button edges move or rotate
// the anchor. On confirm, the cells of the ship are packed into a shadow vector,
// one slot per cycle. The finished vector is then published on the ship bus
// together with a one-cycle readEnabled strobe.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                level; rising edge begins a placement (IDLE/DONE)
//   tamanho[2:0]         ship length; 0 is treated as 1, values above 4 as 4
//   btn_cima/btn_baixo   Y+1 / Y-1 (debounced levels, edge-acting)
//   btn_esq/btn_dir      X-1 / X+1
//   btn_girar            toggle orientation if the rotated ship fits
//   btn_confirma         commit placement
//   bus                  master side of the ship-position bus
//   cursorX, cursorY     anchor cell, 1..GRID
//   horizontal           1 = cells grow +X, 0 = cells grow +Y
//   busy, done           MOVE/WRITE/PUBLISH, DONE
//   estado[2:0]          FSM state, exported for debug
module posicionador_embarcacao #(
  parameter int GRID      = 8,
  parameter int MAX_CELLS = 4,
  parameter int CELL_W    = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] tamanho,
  input  logic       btn_cima,
  input  logic       btn_baixo,
  input  logic       btn_esq,
  input  logic       btn_dir,
  input  logic       btn_girar,
  input  logic       btn_confirma,
  posicionador_embarcacao_if.master bus,
  output logic [3:0] cursorX,
  output logic [3:0] cursorY,
  output logic       horizontal,
  output logic       busy,
  output logic       done,
  output logic [2:0] estado
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_MOVE    = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_PUBLISH = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int          W      = MAX_CELLS * CELL_W;
  localparam logic [3:0]  GRID_C = 4'(GRID);

  logic [2:0]   state;
  logic [2:0]   len;
  logic [1:0]   cnt;
  logic [W-1:0] shadow;

  logic start_q, cima_q, baixo_q, esq_q, dir_q, girar_q, conf_q;
  logic e_start, e_cima, e_baixo, e_esq, e_dir, e_girar, e_conf;

  assign e_start = start        & ~start_q;
  assign e_cima  = btn_cima     & ~cima_q;
  assign e_baixo = btn_baixo    & ~baixo_q;
  assign e_esq   = btn_esq      & ~esq_q;
  assign e_dir   = btn_dir      & ~dir_q;
  assign e_girar = btn_girar    & ~girar_q;
  assign e_conf  = btn_confirma & ~conf_q;

  logic [2:0] len_in;
  always_comb begin
    len_in = tamanho;
    if (tamanho == 3'd0)      len_in = 3'd1;
    else if (tamanho > 3'd4)  len_in = 3'd4;
  end

  // Highest anchor coordinate along the growth axis that keeps the tail on-map.
  logic [3:0] lim, lim_x, lim_y;
  assign lim   = GRID_C + 4'd1 - {1'b0, len};
  assign lim_x = horizontal ? lim : GRID_C;
  assign lim_y = horizontal ? GRID_C : lim;

  // Rotation keeps the anchor, so the new growth axis must have room.
  logic rot_fits;
  assign rot_fits = horizontal ? (cursorY <= lim) : (cursorX <= lim);

  logic [3:0]        cell_x, cell_y;
  logic [CELL_W-1:0] slot;
  assign cell_x = horizontal ? cursorX + {2'b00, cnt} : cursorX;
  assign cell_y = horizontal ? cursorY : cursorY + {2'b00, cnt};

  always_comb begin
    slot       = '0;
    slot[0]    = 1'b1;
    slot[6:3]  = cell_x;
    slot[10:7] = cell_y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                  <= S_IDLE;
      len                    <= 3'd1;
      cnt                    <= 2'd0;
      shadow                 <= '0;
      cursorX                <= 4'd1;
      cursorY                <= 4'd1;
      horizontal             <= 1'b1;
      bus.posicoesEmbarcacao <= '0;
      bus.readEnabled        <= 1'b0;
      start_q                <= 1'b0;
      cima_q                 <= 1'b0;
      baixo_q                <= 1'b0;
      esq_q                  <= 1'b0;
      dir_q                  <= 1'b0;
      girar_q                <= 1'b0;
      conf_q                 <= 1'b0;
    end else begin
      start_q         <= start;
      cima_q          <= btn_cima;
      baixo_q         <= btn_baixo;
      esq_q           <= btn_esq;
      dir_q           <= btn_dir;
      girar_q         <= btn_girar;
      conf_q          <= btn_confirma;
      bus.readEnabled <= 1'b0;

      case (state)
        S_IDLE, S_DONE: begin
          if (e_start) begin
            state      <= S_MOVE;
            cursorX    <= 4'd1;
            cursorY    <= 4'd1;
            horizontal <= 1'b1;
            len        <= len_in;
          end
        end
        S_MOVE: begin
          if (e_conf) begin
            state  <= S_WRITE;
            cnt    <= 2'd0;
            shadow <= '0;
          end else if (e_girar) begin
            if (rot_fits) horizontal <= ~horizontal;
          end else if (e_cima) begin
            if (cursorY < lim_y) cursorY <= cursorY + 4'd1;
          end else if (e_baixo) begin
            if (cursorY > 4'd1) cursorY <= cursorY - 4'd1;
          end else if (e_esq) begin
            if (cursorX > 4'd1) cursorX <= cursorX - 4'd1;
          end else if (e_dir) begin
            if (cursorX < lim_x) cursorX <= cursorX + 4'd1;
          end
        end
        S_WRITE: begin
          shadow[int'(cnt)*CELL_W +: CELL_W] <= slot;
          cnt <= cnt + 2'd1;
          if ({1'b0, cnt} == len - 3'd1) state <= S_PUBLISH;
        end
        S_PUBLISH: begin
          bus.posicoesEmbarcacao <= shadow;
          bus.readEnabled        <= 1'b1;
          state                  <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (state == S_MOVE) || (state == S_WRITE) || (state == S_PUBLISH);
  assign done   = (state == S_DONE);
  assign estado = state;

endmodule

// File: tb/tb_posicionador_embarcacao.sv
module tb_posicionador_embarcacao;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] tamanho;
  logic       btn_cima, btn_baixo, btn_esq, btn_dir, btn_girar, btn_confirma;
  logic [3:0] cursorX, cursorY;
  logic       horizontal, busy, done;
  logic [2:0] estado;

  posicionador_embarcacao_if #(.W(64)) bus_if ();

  posicionador_embarcacao dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .tamanho      (tamanho),
    .btn_cima     (btn_cima),
    .btn_baixo    (btn_baixo),
    .btn_esq      (btn_esq),
    .btn_dir      (btn_dir),
    .btn_girar    (btn_girar),
    .btn_confirma (btn_confirma),
    .bus          (bus_if),
    .cursorX      (cursorX),
    .cursorY      (cursorY),
    .horizontal   (horizontal),
    .busy         (busy),
    .done         (done),
    .estado       (estado)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  int          m_x, m_y, m_len;
  bit          m_hor;
  logic [63:0] m_vec;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int clamp_len(input int t);
    if (t == 0) return 1;
    if (t > 4)  return 4;
    return t;
  endfunction

  // True when every cell of a ship anchored at (x,y) lies inside 1..8.
  function automatic bit ship_fits(input int x, input int y, input bit hor, input int len);
    int tail_x, tail_y;
    tail_x = hor ? x + len - 1 : x;
    tail_y = hor ? y : y + len - 1;
    return (x >= 1) && (y >= 1) && (tail_x <= 8) && (tail_y <= 8);
  endfunction

  function automatic logic [63:0] build_vec(input int x, input int y, input bit hor, input int len);
    logic [63:0] v;
    int cx, cy;
    v = '0;
    for (int k = 0; k < len; k++) begin
      cx = hor ? x + k : x;
      cy = hor ? y : y + k;
      v = v | ((64'(1) | (64'(cx) << 3) | (64'(cy) << 7)) << (16 * k));
    end
    return v;
  endfunction

  // mask: [4] girar [3] cima [2] baixo [1] esq [0] dir; first set bit wins
  task automatic model_move(input logic [4:0] m);
    if (m[4]) begin
      if (ship_fits(m_x, m_y, !m_hor, m_len)) m_hor = !m_hor;
    end else if (m[3]) begin
      if (ship_fits(m_x, m_y + 1, m_hor, m_len)) m_y = m_y + 1;
    end else if (m[2]) begin
      if (ship_fits(m_x, m_y - 1, m_hor, m_len)) m_y = m_y - 1;
    end else if (m[1]) begin
      if (ship_fits(m_x - 1, m_y, m_hor, m_len)) m_x = m_x - 1;
    end else if (m[0]) begin
      if (ship_fits(m_x + 1, m_y, m_hor, m_len)) m_x = m_x + 1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btns(input logic [4:0] m);
    btn_girar = m[4];
    btn_cima  = m[3];
    btn_baixo = m[2];
    btn_esq   = m[1];
    btn_dir   = m[0];
  endtask

  task automatic check_cursor(input string tag);
    check({tag, "_x"},   64'(cursorX),    64'(m_x));
    check({tag, "_y"},   64'(cursorY),    64'(m_y));
    check({tag, "_hor"}, 64'(horizontal), 64'(m_hor));
  endtask

  task automatic press(input logic [4:0] m);
    set_btns(m);
    tick();
    set_btns(5'd0);
    tick();
    model_move(m);
    check_cursor("press");
    check("vec_hold_move", bus_if.posicoesEmbarcacao, m_vec);
  endtask

  task automatic do_start(input int t);
    tamanho = 3'(t);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    m_len = clamp_len(t);
    m_x = 1;
    m_y = 1;
    m_hor = 1'b1;
    check("start_busy", 64'(busy), 64'd1);
    check_cursor("start");
    check("start_vec_hold", bus_if.posicoesEmbarcacao, m_vec);
  endtask

  task automatic do_confirm();
    bit seen;
    logic [63:0] exp;
    exp_q.push_back(build_vec(m_x, m_y, m_hor, m_len));
    seen = 1'b0;
    btn_confirma = 1'b1;
    tick();
    btn_confirma = 1'b0;
    check("write_busy", 64'(busy), 64'd1);
    for (int c = 1; c <= 20 && !seen; c++) begin
      tick();
      if (bus_if.readEnabled) begin
        seen = 1'b1;
        exp = exp_q.pop_front();
        check("strobe_latency", 64'(c), 64'(m_len + 1));
        check("vec_publish", bus_if.posicoesEmbarcacao, exp);
        m_vec = exp;
      end else begin
        check("vec_hold_write", bus_if.posicoesEmbarcacao, m_vec);
      end
    end
    if (!seen) begin
      check("strobe_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
    tick();
    check("strobe_one_cycle", 64'(bus_if.readEnabled), 64'd0);
    check("done_flag", 64'(done), 64'd1);
    check("done_not_busy", 64'(busy), 64'd0);
    check("vec_hold_done", bus_if.posicoesEmbarcacao, m_vec);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_vec"},  bus_if.posicoesEmbarcacao, 64'd0);
    check({tag, "_re"},   64'(bus_if.readEnabled),   64'd0);
    check({tag, "_x"},    64'(cursorX),              64'd1);
    check({tag, "_y"},    64'(cursorY),              64'd1);
    check({tag, "_hor"},  64'(horizontal),           64'd1);
    check({tag, "_busy"}, 64'(busy),                 64'd0);
    check({tag, "_done"}, 64'(done),                 64'd0);
    check({tag, "_idle"}, 64'(estado),               64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int strobes;
    rst_n = 1'b0;
    start = 1'b0;
    tamanho = 3'd1;
    set_btns(5'd0);
    btn_confirma = 1'b0;
    m_vec = '0;
    m_x = 1; m_y = 1; m_hor = 1'b1; m_len = 1;
    repeat (3) tick();
    check_reset_state("por");
    rst_n = 1'b1;
    tick();

    // T2: single cell, dir x3, cima x2
    do_start(1);
    repeat (3) press(5'b00001);
    repeat (2) press(5'b01000);
    do_confirm();
    check("t2_vec_const", bus_if.posicoesEmbarcacao, 64'h0000_0000_0000_01A1);

    // T1: reset in the middle of WRITE
    do_start(4);
    btn_confirma = 1'b1;
    tick();
    btn_confirma = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_reset_state("mid_write");
    tick();
    tick();
    rst_n = 1'b1;
    m_vec = '0;
    strobes = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (bus_if.readEnabled) strobes++;
    end
    check("no_publish_after_reset", 64'(strobes), 64'd0);
    check("idle_after_reset", 64'(busy), 64'd0);

    // T3: length 4 horizontal, saturating dir
    do_start(4);
    repeat (10) press(5'b00001);
    check("t3_x_sat", 64'(cursorX), 64'd5);
    do_confirm();

    // T4: length 3 vertical at X=7, rotation must be refused
    do_start(3);
    press(5'b10000);
    repeat (6) press(5'b00001);
    press(5'b10000);
    check("t4_rot_refused", 64'(horizontal), 64'd0);
    do_confirm();

    // T5: simultaneous buttons, then a held button
    do_start(2);
    press(5'b11001);
    check("t5_girar_only", 64'(horizontal), 64'd0);
    btn_dir = 1'b1;
    repeat (20) tick();
    btn_dir = 1'b0;
    tick();
    model_move(5'b00001);
    check_cursor("t5_hold");
    check("t5_hold_one_cell", 64'(cursorX), 64'd2);
    do_confirm();

    // T6: length clamping and restart from DONE
    do_start(0);
    press(5'b01000);
    do_confirm();
    do_start(7);
    press(5'b10000);
    press(5'b01000);
    do_confirm();

    // Randomized placements
    for (int p = 0; p < 8; p++) begin
      do_start(int'($urandom_range(0, 7)));
      for (int i = 0; i < 15; i++) press(5'($urandom_range(1, 31)));
      do_confirm();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
